// File: rtl/reward_scheduler.sv
// Reward scheduler: spawns a reward, waits for pickup or timeout, runs the picked or
// forced effect on a seconds timer, then recovers and cools down before the next spawn.
module reward_scheduler #(
  parameter int TICK_DIV          = 20000000,
  parameter int EFFECT_SEC        = 30,
  parameter int GRADE_SEC         = 6,
  parameter int RECOVER_SEC       = 10,
  parameter int SPAWN_TIMEOUT_SEC = 15,
  parameter int COOLDOWN_SEC      = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] game_status,
  input  logic       spawn_ack,
  input  logic       pickup,
  input  logic [1:0] pickup_type,
  input  logic [2:0] sw,
  output logic       spawn_req,
  output logic       reward_visible,
  output logic       reward_protected,
  output logic       reward_slowly,
  output logic       reward_grade,
  output logic       speed_recover,
  output logic [5:0] sec_left,
  output logic [2:0] sched_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SPAWN     = 3'd1,
    S_WAIT_PICK = 3'd2,
    S_ACTIVE    = 3'd3,
    S_RECOVER   = 3'd4,
    S_COOLDOWN  = 3'd5
  } state_t;

  // Effect codes share the pickup_type encoding.
  localparam logic [1:0] EFF_NONE = 2'd0;
  localparam logic [1:0] EFF_SLOW = 2'd2;
  localparam logic [1:0] EFF_GRD  = 2'd3;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_t        state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [5:0]    sec_n;
  logic [1:0]    eff, eff_n;
  logic [1:0]    pend, pend_n;
  logic [2:0]    sw_q;

  logic          running;
  logic          tick;
  logic          expire;
  logic [1:0]    force_code;
  logic          force_hit;
  logic          act_go;
  logic [1:0]    act_code;
  logic          restart;

  // Timer length of an effect: grade is short, the others share one duration.
  function automatic logic [5:0] effect_len(input logic [1:0] code);
    effect_len = (code == EFF_GRD) ? 6'(GRADE_SEC) : 6'(EFFECT_SEC);
  endfunction

  // One-hot switch pattern to effect code; anything else means no force.
  function automatic logic [1:0] sw_code(input logic [2:0] s);
    case (s)
      3'b001:  sw_code = 2'd1;
      3'b010:  sw_code = 2'd2;
      3'b100:  sw_code = 2'd3;
      default: sw_code = EFF_NONE;
    endcase
  endfunction

  assign running    = (game_status == 2'b10);
  assign tick       = (presc == PW'(TICK_DIV - 1));
  assign expire     = tick && (sec_left == 6'd1);
  assign force_code = sw_code(sw);
  assign force_hit  = (force_code != EFF_NONE) && (sw != sw_q);

  // State register plus timer, effect, pending-force and switch history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      presc    <= '0;
      sec_left <= '0;
      eff      <= EFF_NONE;
      pend     <= EFF_NONE;
      sw_q     <= '0;
    end else begin
      state    <= state_n;
      presc    <= presc_n;
      sec_left <= sec_n;
      eff      <= eff_n;
      pend     <= pend_n;
      sw_q     <= sw;
    end
  end

  // Next-state logic: abort first, then forces, then pickups, then timer expiry.
  always_comb begin
    state_n  = state;
    sec_n    = sec_left;
    eff_n    = eff;
    pend_n   = EFF_NONE;
    act_go   = 1'b0;
    act_code = EFF_NONE;
    if (!running) begin
      state_n = S_IDLE;
      sec_n   = '0;
      eff_n   = EFF_NONE;
    end else begin
      case (state)
        S_IDLE: begin
          state_n = S_SPAWN;
          sec_n   = '0;
        end
        S_SPAWN: begin
          // A force here waits until the reward has been placed.
          pend_n = force_hit ? force_code : pend;
          if (spawn_ack) begin
            state_n = S_WAIT_PICK;
            sec_n   = 6'(SPAWN_TIMEOUT_SEC);
          end
        end
        S_WAIT_PICK: begin
          if (force_hit) begin
            act_go   = 1'b1;
            act_code = force_code;
          end else if (pend != EFF_NONE) begin
            act_go   = 1'b1;
            act_code = pend;
          end else if (pickup) begin
            if (pickup_type != EFF_NONE) begin
              act_go   = 1'b1;
              act_code = pickup_type;
            end else begin
              state_n = S_COOLDOWN;
              sec_n   = 6'(COOLDOWN_SEC);
            end
          end else if (expire) begin
            state_n = S_COOLDOWN;
            sec_n   = 6'(COOLDOWN_SEC);
          end else if (tick) begin
            sec_n = sec_left - 6'd1;
          end
        end
        S_ACTIVE: begin
          if (force_hit) begin
            act_go   = 1'b1;
            act_code = force_code;
          end else if (expire) begin
            eff_n = EFF_NONE;
            if (eff == EFF_SLOW) begin
              state_n = S_RECOVER;
              sec_n   = 6'(RECOVER_SEC);
            end else begin
              state_n = S_COOLDOWN;
              sec_n   = 6'(COOLDOWN_SEC);
            end
          end else if (tick) begin
            sec_n = sec_left - 6'd1;
          end
        end
        S_RECOVER, S_COOLDOWN: begin
          if (force_hit) begin
            act_go   = 1'b1;
            act_code = force_code;
          end else if (expire) begin
            if (state == S_RECOVER) begin
              state_n = S_COOLDOWN;
              sec_n   = 6'(COOLDOWN_SEC);
            end else begin
              state_n = S_SPAWN;
              sec_n   = '0;
            end
          end else if (tick) begin
            sec_n = sec_left - 6'd1;
          end
        end
        default: begin
          state_n = S_IDLE;
          sec_n   = '0;
          eff_n   = EFF_NONE;
        end
      endcase
      if (act_go) begin
        state_n = S_ACTIVE;
        eff_n   = act_code;
        sec_n   = effect_len(act_code);
      end
    end
    // Prescaler restarts on every entry, including a forced re-entry of ACTIVE.
    restart = act_go || (state_n != state);
    if (!running || restart || tick) presc_n = '0;
    else                             presc_n = presc + PW'(1);
  end

  // Output decode from the registered state and effect.
  always_comb begin
    spawn_req        = (state == S_SPAWN) && !spawn_ack;
    reward_visible   = (state == S_WAIT_PICK);
    reward_protected = (state == S_ACTIVE) && (eff == 2'd1);
    reward_slowly    = (state == S_ACTIVE) && (eff == EFF_SLOW);
    reward_grade     = (state == S_ACTIVE) && (eff == EFF_GRD);
    speed_recover    = (state == S_RECOVER);
    sched_state      = state;
  end

endmodule

// File: tb/tb_reward_scheduler.sv
// Directed bench for reward_scheduler with small timing parameters.
module tb_reward_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] game_status;
  logic       spawn_ack;
  logic       pickup;
  logic [1:0] pickup_type;
  logic [2:0] sw;
  logic       spawn_req, reward_visible, reward_protected, reward_slowly, reward_grade;
  logic       speed_recover;
  logic [5:0] sec_left;
  logic [2:0] sched_state;

  int applied = 0;
  int miscompares = 0;

  reward_scheduler #(
    .TICK_DIV(4), .EFFECT_SEC(3), .GRADE_SEC(2), .RECOVER_SEC(2),
    .SPAWN_TIMEOUT_SEC(3), .COOLDOWN_SEC(2)
  ) dut (
    .clk(clk), .rst(rst), .game_status(game_status), .spawn_ack(spawn_ack),
    .pickup(pickup), .pickup_type(pickup_type), .sw(sw),
    .spawn_req(spawn_req), .reward_visible(reward_visible),
    .reward_protected(reward_protected), .reward_slowly(reward_slowly),
    .reward_grade(reward_grade), .speed_recover(speed_recover),
    .sec_left(sec_left), .sched_state(sched_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0] ptype;
    logic [2:0] swv;
    int         st;
    logic [2:0] flags;   // {grade, slowly, protected}
    int         len;
    int         after;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int got, input int exp);
    applied++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic int flags3;
    return int'({reward_grade, reward_slowly, reward_protected});
  endfunction

  function automatic int all_out;
    return int'({spawn_req, reward_visible, reward_protected, reward_slowly,
                 reward_grade, speed_recover, sec_left, sched_state});
  endfunction

  task automatic do_reset;
    rst = 1'b1; game_status = 2'b00; spawn_ack = 1'b0; pickup = 1'b0;
    pickup_type = 2'd0; sw = 3'b000;
    step; step;
    rst = 1'b0;
  endtask

  // From reset release to the first WAIT_PICK cycle.
  task automatic to_wait;
    game_status = 2'b10;
    step;
    chk("idle_to_spawn_state", sched_state, 1);
    chk("spawn_req_high", spawn_req, 1);
    step; step;
    chk("spawn_req_held", spawn_req, 1);
    spawn_ack = 1'b1;
    #1;
    chk("spawn_req_drops_on_ack", spawn_req, 0);
    step;
    spawn_ack = 1'b0;
    chk("wait_pick_state", sched_state, 2);
    chk("wait_pick_visible", reward_visible, 1);
    chk("wait_pick_sec", sec_left, 3);
  endtask

  initial begin
    int n;
    vecs[0] = '{2'd1, 3'b000, 3, 3'b001, 12, 5};
    vecs[1] = '{2'd2, 3'b000, 3, 3'b010, 12, 4};
    vecs[2] = '{2'd3, 3'b000, 3, 3'b100,  8, 5};
    vecs[3] = '{2'd0, 3'b000, 5, 3'b000,  0, 5};
    vecs[4] = '{2'd3, 3'b001, 3, 3'b001, 12, 5};
    vecs[5] = '{2'd1, 3'b011, 3, 3'b001, 12, 5};
    vecs[6] = '{2'd0, 3'b100, 3, 3'b100,  8, 5};
    vecs[7] = '{2'd2, 3'b010, 3, 3'b010, 12, 4};

    // Asynchronous reset with no clock edge seen yet.
    rst = 1'b1; game_status = 2'b10; spawn_ack = 1'b0; pickup = 1'b0;
    pickup_type = 2'd0; sw = 3'b000;
    #1;
    chk("reset_outputs", all_out(), 0);
    step; step;
    chk("reset_held_outputs", all_out(), 0);

    // Table: pickup/force combinations through the full effect lifecycle.
    for (int i = 0; i < 8; i++) begin
      do_reset;
      to_wait;
      step; step;
      pickup = 1'b1; pickup_type = vecs[i].ptype; sw = vecs[i].swv;
      step;
      pickup = 1'b0; pickup_type = 2'd0;
      chk($sformatf("v%0d_state_after_pick", i), sched_state, vecs[i].st);
      chk($sformatf("v%0d_flags", i), flags3(), int'(vecs[i].flags));
      if (vecs[i].st == 3) begin
        n = 0;
        while (flags3() == int'(vecs[i].flags) && n < 40) begin n++; step; end
        chk($sformatf("v%0d_effect_len", i), n, vecs[i].len);
        chk($sformatf("v%0d_flags_clear", i), flags3(), 0);
        chk($sformatf("v%0d_state_after_effect", i), sched_state, vecs[i].after);
      end
      if (vecs[i].after == 4) begin
        n = 0;
        while (speed_recover && n < 40) begin n++; step; end
        chk($sformatf("v%0d_recover_len", i), n, 8);
      end
      chk($sformatf("v%0d_cooldown_sec", i), sec_left, 2);
      n = 0;
      while (sched_state == 3'd5 && n < 40) begin n++; step; end
      chk($sformatf("v%0d_cooldown_len", i), n, 8);
      chk($sformatf("v%0d_respawn_req", i), spawn_req, 1);
    end

    // Spawn timeout: visible for 12 cycles counting 3,2,1, then cooldown.
    do_reset;
    to_wait;
    n = 0;
    while (reward_visible && n < 40) begin
      if (n % 4 == 0 && n < 12) chk($sformatf("timeout_sec_at_%0d", n), sec_left, 3 - n / 4);
      n++;
      step;
    end
    chk("timeout_visible_len", n, 12);
    chk("timeout_to_cooldown", sched_state, 5);

    // Force during SPAWN is held and applied right after the reward is placed.
    do_reset;
    game_status = 2'b10;
    step;
    sw = 3'b100;
    step;
    chk("pending_stays_spawn", sched_state, 1);
    spawn_ack = 1'b1;
    step;
    spawn_ack = 1'b0;
    chk("pending_wait_pick_cycle", sched_state, 2);
    step;
    chk("pending_applied_state", sched_state, 3);
    chk("pending_applied_grade", reward_grade, 1);
    chk("pending_applied_sec", sec_left, 2);

    // Force on the expiry cycle wins; non-one-hot and zero switches change nothing.
    do_reset;
    to_wait;
    pickup = 1'b1; pickup_type = 2'd3;
    step;
    pickup = 1'b0; pickup_type = 2'd0;
    for (int k = 0; k < 7; k++) step;
    chk("grade_last_cycle_sec", sec_left, 1);
    chk("grade_last_cycle_flag", reward_grade, 1);
    sw = 3'b001;
    step;
    chk("expiry_force_state", sched_state, 3);
    chk("expiry_force_flags", flags3(), 1);
    chk("expiry_force_sec", sec_left, 3);
    sw = 3'b011;
    step;
    chk("non_onehot_keeps_flags", flags3(), 1);
    chk("non_onehot_keeps_sec", sec_left, 3);
    sw = 3'b000;
    step;
    chk("zero_sw_keeps_flags", flags3(), 1);

    // Abort mid-ACTIVE and resume.
    do_reset;
    to_wait;
    pickup = 1'b1; pickup_type = 2'd1;
    step;
    pickup = 1'b0; pickup_type = 2'd0;
    for (int k = 0; k < 4; k++) step;
    chk("abort_pre_sec", sec_left, 2);
    game_status = 2'b01;
    step;
    chk("abort_outputs", all_out(), 0);
    game_status = 2'b10;
    step;
    chk("resume_state", sched_state, 1);
    chk("resume_spawn_req", spawn_req, 1);

    // Asynchronous reset in RECOVER between clock edges.
    do_reset;
    to_wait;
    pickup = 1'b1; pickup_type = 2'd2;
    step;
    pickup = 1'b0; pickup_type = 2'd0;
    n = 0;
    while (reward_slowly && n < 40) begin n++; step; end
    step;
    chk("recover_before_reset", speed_recover, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_recover_low", speed_recover, 0);
    chk("async_reset_state", sched_state, 0);
    step; step;
    chk("reset_hold_state", sched_state, 0);
    rst = 1'b0;
    step;
    chk("release_to_spawn", sched_state, 1);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/reward_scheduler.md
REWARD_SCHEDULER -- requirements
Module: reward_scheduler

Interface
REQ-001 Parameter TICK_DIV, default 20000000, means clk cycles per one-second tick.
REQ-002 Parameter EFFECT_SEC, default 30, means duration of a protected or slowly effect in ticks.
REQ-003 Parameter GRADE_SEC, default 6, means duration of a grade effect in ticks.
REQ-004 Parameter RECOVER_SEC, default 10, means speed_recover hold time after slowly ends, in ticks.
REQ-005 Parameter SPAWN_TIMEOUT_SEC, default 15, means how long a reward stays visible before it is withdrawn, in ticks.
REQ-006 Parameter COOLDOWN_SEC, default 5, means the gap between a reward ending and the next spawn, in ticks.
REQ-007 clk  in  1  sole clock; all state changes on its rising edge.
REQ-008 rst  in  1  reset, asynchronous and active-high.
REQ-009 game_status  in  2  the scheduler runs only while this equals 2'b10.
REQ-010 spawn_ack  in  1  random generator has placed a reward (1-cycle pulse).
REQ-011 pickup  in  1  snake head is on the visible reward (1-cycle pulse).
REQ-012 pickup_type  in  2  reward type at the pickup: 1 protected, 2 slowly, 3 grade, 0 none.
REQ-013 sw  in  3  force switches, one-hot: bit0 protected, bit1 slowly, bit2 grade.
REQ-014 spawn_req  out  1  request to the random generator for a new reward position and type.
REQ-015 reward_visible  out  1  a reward is on the field.
REQ-016 reward_protected, reward_slowly, reward_grade  out  1 each  active effect; at most one is high.
REQ-017 speed_recover  out  1  restore-speed pulse window after slowly.
REQ-018 sec_left  out  6  ticks remaining in the current timed state; 0 in IDLE and SPAWN.
REQ-019 sched_state  out  3  current state encoding: IDLE=0, SPAWN=1, WAIT_PICK=2, ACTIVE=3, RECOVER=4, COOLDOWN=5.

Function
REQ-020 Prescaler: count 0..TICK_DIV-1 while running; tick is a 1-cycle pulse at TICK_DIV-1; clear to 0 on every state entry and whenever not running.
REQ-021 Timed-state entry: load sec_left with N; decrement it on each tick; leave the state on the tick that sees sec_left==1, giving exactly N*TICK_DIV cycles in the state.
REQ-022 IDLE: go to SPAWN on the first cycle game_status==2'b10.
REQ-023 SPAWN: hold spawn_req=1 until spawn_ack; on spawn_ack go to WAIT_PICK and drop spawn_req in the same cycle; no timeout.
REQ-024 WAIT_PICK: reward_visible=1; N=SPAWN_TIMEOUT_SEC; on timeout go to COOLDOWN.
REQ-025 WAIT_PICK on pickup with type 1/2/3: go to ACTIVE with the matching flag set. With type 0: go to COOLDOWN. pickup is ignored in every other state.
REQ-026 ACTIVE: N=EFFECT_SEC for protected or slowly, GRADE_SEC for grade; exactly one flag high.
REQ-027 ACTIVE expiry: slowly goes to RECOVER; other effects go to COOLDOWN; the flag clears on the expiry cycle.
REQ-028 RECOVER: speed_recover=1 and all effect flags 0; N=RECOVER_SEC; then go to COOLDOWN.
REQ-029 COOLDOWN: N=COOLDOWN_SEC; then go to SPAWN.
REQ-030 Force: sample sw each cycle into sw_q. A force occurs when sw is one-hot and sw!=sw_q. It is honoured in WAIT_PICK, ACTIVE, RECOVER and COOLDOWN.
REQ-031 A force enters ACTIVE with the forced effect, clears reward_visible and speed_recover, and restarts the timer even if the same effect is already active.
REQ-032 A force in SPAWN is held pending and applied on the cycle after spawn_ack.
REQ-033 Non-one-hot or all-zero sw never forces and never cancels an effect.
REQ-034 Simultaneous force and pickup in WAIT_PICK: the force wins; the pickup is dropped.
REQ-035 Simultaneous tick-expiry and force: the force wins.
REQ-036 When game_status!=2'b10: next cycle go to IDLE, clear all outputs, the prescaler, the pending force and sec_left (synchronous abort mid-operation).

Reset
REQ-037 rst asynchronously forces IDLE, sets every output, prescaler, sw_q and pending force to 0, and holds them while asserted.
REQ-038 First running cycle after rst release behaves as IDLE entry per REQ-022.

Verification (TICK_DIV=4, EFFECT_SEC=3, GRADE_SEC=2, RECOVER_SEC=2, SPAWN_TIMEOUT_SEC=3, COOLDOWN_SEC=2)
REQ-039 Spawn and pick: status=2'b10, spawn_ack at cycle 5, pickup type 2 at cycle 9 -> reward_slowly high for exactly 12 cycles, then speed_recover for 8, COOLDOWN for 8, then spawn_req=1.
REQ-040 Timeout: no pickup after spawn_ack -> reward_visible high exactly 12 cycles; sec_left reads 3,2,1; then COOLDOWN.
REQ-041 Grade: pickup type 3 -> reward_grade high 8 cycles; sched_state 3 then 5; no RECOVER.
REQ-042 Force priority: sw 000->001 on the same cycle as a type-3 pickup -> reward_protected=1, reward_grade stays 0. sw 001->011 -> no change.
REQ-043 Abort: status 2'b10->2'b01 mid-ACTIVE with sec_left=2 -> next cycle all outputs 0 and sched_state=0. Returning to 2'b10 -> spawn_req the following cycle.
REQ-044 Async reset: assert rst mid-RECOVER between clk edges -> speed_recover falls without a clock edge; state stays IDLE until release.
